// File: rtl/sync_ram_port_master.sv
// Burst master for a synchronous single-port RAM with a shared tristate data bus.
// Optional write-verify (read back and compare each word) is enabled by RAM_MASTER_VERIFY_EN.
`timescale 1ns/1ps
module sync_ram_port_master #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [ADDR-1:0]  req_len,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             wdata_pop,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_last,
  output logic             busy,
  output logic             verify_err,
  output logic [ADDR-1:0]  ram_addr,
  output logic             ram_cs,
  output logic             ram_wr_rd,
  output logic             ram_oe,
  inout  wire  [WIDTH-1:0] ram_data
);

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA
`ifdef RAM_MASTER_VERIFY_EN
    ,
    VF_ADDR,
    VF_DATA
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [ADDR-1:0]  cnt_q, cnt_d;
  logic [ADDR-1:0]  len_q, len_d;
  logic             rsp_valid_q;
  logic             rsp_last_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic [ADDR-1:0]  next_addr;
  logic             last_word;
  logic             drive_bus;
  logic             rd_sample;
`ifdef RAM_MASTER_VERIFY_EN
  logic             vf_check;
  logic [WIDTH-1:0] hold_q;
  logic             err_q;
`endif

  // Word address walks through the attached RAM and wraps at its real depth.
  assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign last_word = (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ram_cs    = 1'b0;
    ram_wr_rd = 1'b0;
    ram_oe    = 1'b0;
    wdata_pop = 1'b0;
    drive_bus = 1'b0;
    rd_sample = 1'b0;
`ifdef RAM_MASTER_VERIFY_EN
    vf_check  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
          state_d = req_wr ? WR : RD_ADDR;
        end
      end
      WR: begin
        ram_cs    = 1'b1;
        ram_wr_rd = 1'b1;
        drive_bus = 1'b1;
        wdata_pop = 1'b1;
`ifdef RAM_MASTER_VERIFY_EN
        state_d   = VF_ADDR;
`else
        if (last_word) begin
          state_d = IDLE;
        end else begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 1'b1;
        end
`endif
      end
`ifdef RAM_MASTER_VERIFY_EN
      VF_ADDR: begin
        ram_cs  = 1'b1;
        state_d = VF_DATA;
      end
      VF_DATA: begin
        ram_cs   = 1'b1;
        ram_oe   = 1'b1;
        vf_check = 1'b1;
        if (last_word) begin
          state_d = IDLE;
        end else begin
          addr_d  = next_addr;
          cnt_d   = cnt_q + 1'b1;
          state_d = WR;
        end
      end
`endif
      RD_ADDR: begin
        ram_cs  = 1'b1;
        addr_d  = next_addr;
        state_d = RD_DATA;
      end
      // The RAM output holds the previous address's word while the next address is presented.
      RD_DATA: begin
        ram_cs    = 1'b1;
        ram_oe    = 1'b1;
        rd_sample = 1'b1;
        addr_d    = next_addr;
        if (last_word) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rsp_valid_q <= rd_sample;
      rsp_last_q  <= rd_sample & last_word;
      if (rd_sample) begin
        rsp_rdata_q <= ram_data;
      end
    end
  end

`ifdef RAM_MASTER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (state_q == WR) begin
      hold_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (vf_check && (ram_data != hold_q)) begin
      err_q <= 1'b1;
    end
  end

  assign verify_err = err_q;
`else
  assign verify_err = 1'b0;
`endif

  assign ram_data  = drive_bus ? req_wdata : {WIDTH{1'bz}};
  assign ram_addr  = addr_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sync_ram_port_master.sv
// Bench for sync_ram_port_master: behavioural RAM on the shared bus plus an array model of its contents.
// Covers RAM_MASTER_VERIFY_EN both defined and undefined.
`timescale 1ns/1ps
module tb_sync_ram_port_master;

`ifdef RAM_MASTER_VERIFY_EN
  localparam int STEP = 3;
`else
  localparam int STEP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [1:0] req_addr = '0;
  logic [1:0] req_len = '0;
  logic [7:0] req_wdata = '0;
  logic       wdata_pop, rsp_valid, rsp_last, busy, verify_err;
  logic [7:0] rsp_rdata;
  logic [1:0] ram_addr;
  logic       ram_cs, ram_wr_rd, ram_oe;
  wire  [7:0] ram_data;

  int checks = 0;
  int errors = 0;

  sync_ram_port_master #(.WIDTH(8), .ADDR(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .wdata_pop(wdata_pop),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .busy(busy),
    .verify_err(verify_err), .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_wr_rd(ram_wr_rd),
    .ram_oe(ram_oe), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Attached RAM; 'stuck' pins bit 0 of its output high.
  logic [7:0] mem [4];
  logic [7:0] ram_q = '0;
  logic       stuck = 1'b0;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wr_rd && !ram_oe) mem[ram_addr] <= ram_data;
      else if (!ram_wr_rd)      ram_q <= mem[ram_addr];
    end
  end
  assign ram_data = (ram_cs && ram_oe) ? (ram_q | {7'b0, stuck}) : 8'bz;

  always @(negedge clk) begin
    checks++;
    if (ram_oe && ram_wr_rd) begin
      errors++;
      $display("FAIL bus_clash oe=%b wr_rd=%b required no overlap", ram_oe, ram_wr_rd);
    end
  end

  // Reference model of RAM contents and per-transaction observations.
  logic [7:0] ref_mem [4];
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [8];
  int         rcyc [8];
  logic       rlast [8];
  int busy_cyc, pops, first_pop, last_pop, ready_bad, nrsp;

  task automatic issue(input logic wr, input logic [1:0] a, input logic [1:0] l);
    int k;
    @(negedge clk);
    req_wr = wr; req_addr = a; req_len = l; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got=%b required=1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_write(input logic [1:0] a, input logic [1:0] l);
    int  idx;
    logic p;
    req_wdata = wbuf[0];
    issue(1'b1, a, l);
    idx = 0; busy_cyc = 0; pops = 0; first_pop = -1; last_pop = -1; ready_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      p = wdata_pop;
      if (busy) begin
        busy_cyc++;
        if (req_ready) ready_bad++;
      end
      if (p) begin
        pops++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
      if (!busy) break;
      @(posedge clk);
      #1;
      if (p && idx < 3) begin
        idx++;
        req_wdata = wbuf[idx];
      end
    end
    for (int i = 0; i <= int'(l); i++) ref_mem[(int'(a) + i) % 4] = wbuf[i];
  endtask

  task automatic run_read(input logic [1:0] a, input logic [1:0] l);
    issue(1'b0, a, l);
    busy_cyc = 0; ready_bad = 0; nrsp = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cyc++;
        if (req_ready) ready_bad++;
      end
      if (rsp_valid) begin
        if (nrsp < 8) begin
          rbuf[nrsp] = rsp_rdata; rcyc[nrsp] = c; rlast[nrsp] = rsp_last;
        end
        nrsp++;
      end
      if (!busy && c >= int'(l) + 4) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_cs, ram_wr_rd, ram_oe, ram_addr, rsp_valid, rsp_last, rsp_rdata, wdata_pop, busy, verify_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs cs=%b wr=%b oe=%b addr=%0d rv=%b rl=%b rd=%h pop=%b busy=%b err=%b required all 0",
               ram_cs, ram_wr_rd, ram_oe, ram_addr, rsp_valid, rsp_last, rsp_rdata, wdata_pop, busy, verify_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b required=1", req_ready);
    end
  endtask

  task automatic test_basic;
    wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3; wbuf[3] = 8'h00;
    run_write(2'd1, 2'd2);
    checks++;
    if (pops != 3 || first_pop != 1 || last_pop != 1 + 2 * STEP || busy_cyc != 3 * STEP) begin
      errors++;
      $display("FAIL basic_write pops=%0d first=%0d last=%0d busy=%0d required 3/1/%0d/%0d",
               pops, first_pop, last_pop, busy_cyc, 1 + 2 * STEP, 3 * STEP);
    end
    run_read(2'd1, 2'd2);
    checks++;
    if (nrsp != 3 || rbuf[0] !== 8'hA1 || rbuf[1] !== 8'hB2 || rbuf[2] !== 8'hC3) begin
      errors++;
      $display("FAIL basic_read_data n=%0d got=%h %h %h required 3 A1 B2 C3", nrsp, rbuf[0], rbuf[1], rbuf[2]);
    end
    checks++;
    if (rcyc[0] != 3 || rcyc[1] != 4 || rcyc[2] != 5 || {rlast[0], rlast[1], rlast[2]} !== 3'b001 || busy_cyc != 4) begin
      errors++;
      $display("FAIL basic_read_timing cyc=%0d,%0d,%0d last=%b%b%b busy=%0d required 3,4,5 001 4",
               rcyc[0], rcyc[1], rcyc[2], rlast[0], rlast[1], rlast[2], busy_cyc);
    end
  endtask

  task automatic test_wrap;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    run_write(2'd3, 2'd1);
    run_read(2'd0, 2'd0);
    checks++;
    if (nrsp != 1 || rbuf[0] !== 8'h22 || rlast[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_write n=%0d got=%h last=%b required 1 22 1", nrsp, rbuf[0], rlast[0]);
    end
    run_read(2'd3, 2'd1);
    checks++;
    if (nrsp != 2 || rbuf[0] !== 8'h11 || rbuf[1] !== 8'h22) begin
      errors++;
      $display("FAIL wrap_read n=%0d got=%h %h required 2 11 22", nrsp, rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_full_depth;
    logic ok;
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    run_write(2'd0, 2'd3);
    run_read(2'd0, 2'd3);
    ok = (nrsp == 4) && (busy_cyc == 5);
    for (int k = 0; k < 4; k++)
      if (rcyc[k] != 3 + k || rbuf[k] !== ref_mem[k] || rlast[k] !== (k == 3)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_depth n=%0d busy=%0d got=%h %h %h %h required 4 5 %h %h %h %h",
               nrsp, busy_cyc, rbuf[0], rbuf[1], rbuf[2], rbuf[3], ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]);
    end
  endtask

  task automatic test_random;
    logic [1:0] a, l;
    logic       ok;
    for (int it = 0; it < 24; it++) begin
      a = 2'($urandom_range(0, 3));
      l = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        run_write(a, l);
        checks++;
        if (pops != int'(l) + 1 || first_pop != 1 || last_pop != 1 + int'(l) * STEP ||
            busy_cyc != (int'(l) + 1) * STEP || ready_bad != 0) begin
          errors++;
          $display("FAIL rand_write it=%0d pops=%0d first=%0d last=%0d busy=%0d rdy=%0d required %0d/1/%0d/%0d/0",
                   it, pops, first_pop, last_pop, busy_cyc, ready_bad, int'(l) + 1, 1 + int'(l) * STEP, (int'(l) + 1) * STEP);
        end
      end else begin
        run_read(a, l);
        ok = (nrsp == int'(l) + 1) && (busy_cyc == int'(l) + 2) && (ready_bad == 0);
        for (int k = 0; k <= int'(l); k++)
          if (rcyc[k] != 3 + k || rbuf[k] !== ref_mem[(int'(a) + k) % 4] || rlast[k] !== (k == int'(l))) ok = 1'b0;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL rand_read it=%0d addr=%0d len=%0d n=%0d busy=%0d rdy=%0d first=%h required n=%0d busy=%0d first=%h",
                   it, a, l, nrsp, busy_cyc, ready_bad, rbuf[0], int'(l) + 1, int'(l) + 2, ref_mem[a]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc, n;
    @(negedge clk);
    req_wr = 1'b0; req_addr = 2'd0; req_len = 2'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 2'd2; req_len = 2'd0;
    acc = -1; n = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (n < 8) begin rbuf[n] = rsp_rdata; rcyc[n] = c; end
        n++;
      end
      if (req_valid && req_ready && acc < 0) begin
        acc = c;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (acc != 6 || n != 5) begin
      errors++;
      $display("FAIL holdoff_accept acc=%0d n=%0d required 6 5", acc, n);
    end
    checks++;
    if (rcyc[4] != 9 || rbuf[4] !== ref_mem[2] || rbuf[0] !== ref_mem[0] || rbuf[3] !== ref_mem[3]) begin
      errors++;
      $display("FAIL holdoff_data cyc=%0d got=%h %h %h required 9 %h %h %h",
               rcyc[4], rbuf[4], rbuf[0], rbuf[3], ref_mem[2], ref_mem[0], ref_mem[3]);
    end
  endtask

  task automatic test_reset_mid_read;
    int seen, extra;
    issue(1'b0, 2'd0, 2'd3);
    seen = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = c; break; end
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL midrst_first_rsp cyc=%0d required 3", seen);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_cs, ram_wr_rd, ram_oe, ram_addr, rsp_valid, busy} !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state cs=%b wr=%b oe=%b addr=%0d rv=%b busy=%b ready=%b required 0s ready=1",
               ram_cs, ram_wr_rd, ram_oe, ram_addr, rsp_valid, busy, req_ready);
    end
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL midrst_quiet activity=%0d required 0", extra);
    end
  endtask

  task automatic test_verify;
`ifdef RAM_MASTER_VERIFY_EN
    checks++;
    if (verify_err !== 1'b0) begin
      errors++;
      $display("FAIL verify_clean got=%b required 0", verify_err);
    end
    stuck = 1'b1;
    wbuf[0] = 8'h40;
    run_write(2'd2, 2'd0);
    stuck = 1'b0;
    checks++;
    if (verify_err !== 1'b1 || busy_cyc != 3 || pops != 1) begin
      errors++;
      $display("FAIL verify_set err=%b busy=%0d pops=%0d required 1 3 1", verify_err, busy_cyc, pops);
    end
    wbuf[0] = 8'h5A;
    run_write(2'd0, 2'd0);
    checks++;
    if (verify_err !== 1'b1) begin
      errors++;
      $display("FAIL verify_sticky got=%b required 1", verify_err);
    end
`else
    wbuf[0] = 8'h5A;
    run_write(2'd2, 2'd0);
    checks++;
    if (busy_cyc != 1 || pops != 1 || verify_err !== 1'b0) begin
      errors++;
      $display("FAIL single_write busy=%0d pops=%0d err=%b required 1 1 0", busy_cyc, pops, verify_err);
    end
    run_read(2'd2, 2'd0);
    checks++;
    if (nrsp != 1 || rbuf[0] !== 8'h5A) begin
      errors++;
      $display("FAIL single_readback n=%0d got=%h required 1 5A", nrsp, rbuf[0]);
    end
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full_depth();
    test_random();
    test_back_to_back();
    test_reset_mid_read();
    test_verify();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_ram_port_master.md
SYNC_RAM_PORT_MASTER -- requirements
Module: sync_ram_port_master

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data word width; ADDR, default 2, address width; DEPTH, default 4, words in the attached RAM, with DEPTH <= 2^ADDR.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock, shared with the attached RAM.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  burst request present.
REQ-006 req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-007 req_wr  in  1  burst type: 1 = write, 0 = read.
REQ-008 req_addr  in  ADDR  first word address of the burst.
REQ-009 req_len  in  ADDR  burst length minus 1, so one request moves 1 to 2^ADDR words.
REQ-010 req_wdata  in  WIDTH  current write word; it is consumed in any cycle where wdata_pop is high.
REQ-011 wdata_pop  out  1  strobe marking the cycle in which req_wdata is written; the user presents the next word by the following cycle.
REQ-012 rsp_valid  out  1  one-cycle pulse per read word, with no backpressure.
REQ-013 rsp_rdata  out  WIDTH  read word, valid while rsp_valid is high.
REQ-014 rsp_last  out  1  high with the final rsp_valid of a read burst.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 verify_err  out  1  sticky write-verify mismatch flag (see Configuration).
REQ-017 ram_addr  out  ADDR  RAM address.
REQ-018 ram_cs  out  1  RAM chip select.
REQ-019 ram_wr_rd  out  1  RAM write enable.
REQ-020 ram_oe  out  1  RAM output enable.
REQ-021 ram_data  inout  WIDTH  shared data bus; the block drives it only while ram_wr_rd=1 and ram_oe=0, and leaves it high-impedance otherwise.

Function
REQ-022 RAM pin protocol: a write occurs at an edge with ram_wr_rd=1, ram_oe=0, ram_cs=1; a read registers mem[ram_addr] at an edge with ram_cs=1; the RAM drives the bus combinationally while ram_cs=1 and ram_oe=1.
REQ-023 The FSM states SHALL be IDLE, WR, RD_ADDR, RD_DATA, plus VF_ADDR and VF_DATA when RAM_MASTER_VERIFY_EN is defined.
REQ-024 Transitions: IDLE goes to WR on an accepted write request and to RD_ADDR on an accepted read request; there is no cycle in which the block is neither idle nor on the bus.
REQ-025 WR: drive ram_cs=1, ram_wr_rd=1, ram_oe=0, bus=req_wdata, and wdata_pop=1; one word per cycle; after the last word, return to IDLE.
REQ-026 RD_ADDR: lasts one cycle with ram_cs=1, ram_wr_rd=0, ram_oe=0, ram_addr=first address; then go to RD_DATA.
REQ-027 RD_DATA is pipelined with ram_cs=1, ram_oe=1: each cycle the block samples ram_data into rsp_rdata (rsp_valid one cycle later) while ram_addr presents the next address.
REQ-028 RD_DATA exits after N words; an N-word read occupies the bus for N+1 cycles, and the first rsp_valid arrives 3 cycles after acceptance.
REQ-029 Addresses SHALL increment by 1 per word and wrap from DEPTH-1 to 0.
REQ-030 Idle bus outputs: ram_cs=0, ram_wr_rd=0, ram_oe=0, bus released.
REQ-031 ram_oe and a driven bus SHALL never be active in the same cycle.
REQ-032 A request presented while busy SHALL be held off by req_ready=0, never dropped.

Reset
REQ-033 While rst=1 at an edge: state goes to IDLE and the in-flight burst is abandoned.
REQ-034 Reset values: ram_cs=0, ram_wr_rd=0, ram_oe=0, ram_addr=0, bus released, rsp_valid=0, rsp_last=0, rsp_rdata=0, wdata_pop=0, busy=0, verify_err=0.
REQ-035 req_ready SHALL be 1 in the cycle after rst deasserts.

Configuration
REQ-036 With macro RAM_MASTER_VERIFY_EN defined, each write word follows WR -> VF_ADDR (read same address) -> VF_DATA (ram_oe=1, compare bus against the held word), 3 cycles per word; wdata_pop pulses in WR only.
REQ-037 On a mismatch, verify_err SHALL set and stay set until rst.
REQ-038 Without the macro, VF states are absent, writes take 1 cycle per word, and verify_err is tied to 0.

Verification
REQ-039 Write addr=1, len=2, data A1,B2,C3 -> wdata_pop high for 3 cycles; then read addr=1, len=2 -> rsp_rdata A1,B2,C3, rsp_last on C3, first rsp 3 cycles after accept.
REQ-040 Wrap: write addr=3, len=1, data 11,22 -> a read of addr 0 returns 22 (DEPTH=4).
REQ-041 Full-depth read addr=0, len=3 -> 4 rsp pulses in 4 consecutive cycles, bus busy for 5 cycles.
REQ-042 rst asserted mid read burst after 1 word -> next cycle all RAM outputs 0, no further rsp_valid, req_ready=1.
REQ-043 RAM_MASTER_VERIFY_EN defined, bench forces a stuck bus bit during VF_DATA -> verify_err=1 and it persists; with the macro undefined, 1-word write takes 1 cycle and verify_err=0.
REQ-044 Bus check: every cycle, assert that ram_oe=1 and block-driven ram_data never coincide.
